pipelined_control_unit: RTL and testbench

- Successor to the single-cycle MIPS control decoder.
- Decodes the ID-stage opcode into a wider control bundle with a parametrised ALU-op width and RegDst/MemtoReg modes for addi/andi/ori/bne/jal.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Generates load-use stall, control-hazard flush and PC-select, plus a sticky illegal-opcode flag and a saturating stall counter.

---
 rtl/cu_pkg.sv | 69 ++++++
 rtl/pipelined_control_unit_decode.sv | 86 ++++++++
 rtl/pipelined_control_unit.sv | 112 +++++++++++
 tb/tb_pipelined_control_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings and control-bundle types for the pipelined MIPS control unit.
package cu_pkg;

    localparam int OPC_W      = 6;
    localparam int ALU_CODE_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_FUNCT = 3'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND   = 3'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = 3'd4;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    typedef struct packed {
        logic [1:0]            reg_dst;
        logic                  alu_src;
        logic [ALU_CODE_W-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_ctrl_t;

    // Fields that travel down the pipeline; jump is consumed in ID only.
    typedef struct packed {
        logic      branch;
        logic      br_ne;
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } pipe_ctrl_t;

    typedef struct packed {
        logic       jump;
        pipe_ctrl_t pipe;
    } ctrl_t;

    localparam ctrl_t      CTRL_BUBBLE = '0;
    localparam pipe_ctrl_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_decode.sv
// Combinational ID-stage decoder: opcode to control bundle and register-read usage.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic                o_uses_rs,
    output logic                o_uses_rt,
    output logic                o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_uses_rs = 1'b0;
        o_uses_rt = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OPCODE_W'(OP_RTYPE): begin
                o_ctrl.pipe.ex.reg_dst   = RD_RD;
                o_ctrl.pipe.ex.alu_op    = ALU_FUNCT;
                o_ctrl.pipe.wb.reg_write = 1'b1;
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                o_ctrl.pipe.ex.alu_src    = 1'b1;
                o_ctrl.pipe.ex.alu_op     = ALU_ADD;
                o_ctrl.pipe.mem.mem_read  = 1'b1;
                o_ctrl.pipe.wb.reg_write  = 1'b1;
                o_ctrl.pipe.wb.mem_to_reg = MTR_MEM;
                o_uses_rs = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                o_ctrl.pipe.ex.alu_src    = 1'b1;
                o_ctrl.pipe.ex.alu_op     = ALU_ADD;
                o_ctrl.pipe.mem.mem_write = 1'b1;
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                o_ctrl.pipe.ex.alu_op = ALU_SUB;
                o_ctrl.pipe.branch    = 1'b1;
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OPCODE_W'(OP_BNE): begin
                o_ctrl.pipe.ex.alu_op = ALU_SUB;
                o_ctrl.pipe.branch    = 1'b1;
                o_ctrl.pipe.br_ne     = 1'b1;
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                o_ctrl.pipe.ex.alu_src   = 1'b1;
                o_ctrl.pipe.ex.alu_op    = ALU_ADD;
                o_ctrl.pipe.wb.reg_write = 1'b1;
                o_uses_rs = 1'b1;
            end
            OPCODE_W'(OP_ANDI): begin
                o_ctrl.pipe.ex.alu_src   = 1'b1;
                o_ctrl.pipe.ex.alu_op    = ALU_AND;
                o_ctrl.pipe.wb.reg_write = 1'b1;
                o_uses_rs = 1'b1;
            end
            OPCODE_W'(OP_ORI): begin
                o_ctrl.pipe.ex.alu_src   = 1'b1;
                o_ctrl.pipe.ex.alu_op    = ALU_OR;
                o_ctrl.pipe.wb.reg_write = 1'b1;
                o_uses_rs = 1'b1;
            end
            OPCODE_W'(OP_J): begin
                o_ctrl.jump = 1'b1;
            end
            OPCODE_W'(OP_JAL): begin
                o_ctrl.jump               = 1'b1;
                o_ctrl.pipe.ex.reg_dst    = RD_R31;
                o_ctrl.pipe.wb.reg_write  = 1'b1;
                o_ctrl.pipe.wb.mem_to_reg = MTR_PC4;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX..MEM/WB control registers,
// load-use stall, branch/jump flush and PC select, illegal-op flag, stall counter.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic [REG_W-1:0]    IdRs,
    input  logic [REG_W-1:0]    IdRt,
    input  logic [REG_W-1:0]    ExRt,
    input  logic                ExZero,
    output logic [1:0]          Ex_RegDst,
    output logic                Ex_ALUSrc,
    output logic [ALUOP_W-1:0]  Ex_ALUOp,
    output logic                Mem_MemRead,
    output logic                Mem_MemWrite,
    output logic                Wb_RegWrite,
    output logic [1:0]          Wb_MemtoReg,
    output logic [1:0]          PCSel,
    output logic                Stall,
    output logic                FlushIfId,
    output logic                IllegalOp,
    output logic [CNT_W-1:0]    StallCount
);

    ctrl_t      w_id_ctrl;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_illegal;
    logic       w_load_use;
    logic       w_br_taken;
    logic       w_stall;
    logic       w_jump_go;
    logic       w_flush;

    pipe_ctrl_t r_idex;
    mem_ctrl_t  r_exmem_mem;
    wb_ctrl_t   r_exmem_wb;
    wb_ctrl_t   r_memwb_wb;
    logic       r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    cu_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode  (OpCode),
        .o_ctrl    (w_id_ctrl),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt),
        .o_illegal (w_illegal)
    );

    assign w_load_use = r_idex.mem.mem_read && (ExRt != '0) &&
                        ((w_uses_rs && (ExRt == IdRs)) || (w_uses_rt && (ExRt == IdRt)));
    assign w_br_taken = r_idex.branch & (ExZero ^ r_idex.br_ne);
    // A taken branch wins: the instruction in ID is on the wrong path anyway.
    assign w_stall    = w_load_use & ~w_br_taken;
    // ID opcode is live during reset, so the jump path is masked explicitly.
    assign w_jump_go  = w_id_ctrl.jump & ~w_stall & ~RST;
    assign w_flush    = w_br_taken | w_jump_go;

    always_comb begin
        PCSel = PCSEL_SEQ;
        if (w_br_taken)     PCSel = PCSEL_BR;
        else if (w_jump_go) PCSel = PCSEL_JMP;
    end

    assign Stall     = w_stall;
    assign FlushIfId = w_flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idex      <= PIPE_BUBBLE;
            r_exmem_mem <= '0;
            r_exmem_wb  <= '0;
            r_memwb_wb  <= '0;
        end else begin
            // jal flushes IF/ID but itself proceeds, so only hazards bubble ID/EX.
            r_idex      <= (w_load_use || w_br_taken) ? PIPE_BUBBLE : w_id_ctrl.pipe;
            r_exmem_mem <= r_idex.mem;
            r_exmem_wb  <= r_idex.wb;
            r_memwb_wb  <= r_exmem_wb;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_illegal && !w_stall && !w_flush) r_illegal <= 1'b1;
            if (w_stall && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign Ex_RegDst    = r_idex.ex.reg_dst;
    assign Ex_ALUSrc    = r_idex.ex.alu_src;
    assign Ex_ALUOp     = ALUOP_W'(r_idex.ex.alu_op);
    assign Mem_MemRead  = r_exmem_mem.mem_read;
    assign Mem_MemWrite = r_exmem_mem.mem_write;
    assign Wb_RegWrite  = r_memwb_wb.reg_write;
    assign Wb_MemtoReg  = r_memwb_wb.mem_to_reg;
    assign IllegalOp    = r_illegal;
    assign StallCount   = r_stall_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit with hand-computed expected bundles.
module tb_pipelined_control_unit;

    localparam int OW = 6;
    localparam int RW = 5;
    localparam int AW = 3;
    localparam int CW = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_ILL  = 6'b111111;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [OW-1:0] OpCode = '0;
    logic [RW-1:0] IdRs = '0;
    logic [RW-1:0] IdRt = '0;
    logic [RW-1:0] ExRt = '0;
    logic          ExZero = 1'b0;
    logic [1:0]    Ex_RegDst;
    logic          Ex_ALUSrc;
    logic [AW-1:0] Ex_ALUOp;
    logic          Mem_MemRead;
    logic          Mem_MemWrite;
    logic          Wb_RegWrite;
    logic [1:0]    Wb_MemtoReg;
    logic [1:0]    PCSel;
    logic          Stall;
    logic          FlushIfId;
    logic          IllegalOp;
    logic [CW-1:0] StallCount;

    int n_chk = 0;
    int n_err = 0;

    pipelined_control_unit #(
        .OPCODE_W (OW), .REG_W (RW), .ALUOP_W (AW), .CNT_W (CW)
    ) dut (
        .CLK (CLK), .RST (RST), .OpCode (OpCode), .IdRs (IdRs), .IdRt (IdRt),
        .ExRt (ExRt), .ExZero (ExZero),
        .Ex_RegDst (Ex_RegDst), .Ex_ALUSrc (Ex_ALUSrc), .Ex_ALUOp (Ex_ALUOp),
        .Mem_MemRead (Mem_MemRead), .Mem_MemWrite (Mem_MemWrite),
        .Wb_RegWrite (Wb_RegWrite), .Wb_MemtoReg (Wb_MemtoReg),
        .PCSel (PCSel), .Stall (Stall), .FlushIfId (FlushIfId),
        .IllegalOp (IllegalOp), .StallCount (StallCount)
    );

    always #5 CLK = ~CLK;

    // Packed views: ex={RegDst,ALUSrc,ALUOp}, mem={MemRead,MemWrite}, wb={RegWrite,MemtoReg}
    logic [5:0] t1_op  [6] = '{T_R, T_LW, T_SW, T_ADDI, T_ANDI, T_ORI};
    logic [5:0] t1_ex  [6] = '{6'b010010, 6'b001000, 6'b001000, 6'b001000, 6'b001011, 6'b001100};
    logic [1:0] t1_mem [6] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [2:0] t1_wb  [6] = '{3'b100, 3'b101, 3'b000, 3'b100, 3'b100, 3'b100};

    logic [5:0] t3_op  [4] = '{T_BEQ, T_BEQ, T_BNE, T_BNE};
    logic       t3_z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       t3_tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic logic [31:0] ex_v();
        return 32'({Ex_RegDst, Ex_ALUSrc, Ex_ALUOp});
    endfunction
    function automatic logic [31:0] mem_v();
        return 32'({Mem_MemRead, Mem_MemWrite});
    endfunction
    function automatic logic [31:0] wb_v();
        return 32'({Wb_RegWrite, Wb_MemtoReg});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input int rs, input int rt,
                         input int exrt, input logic z);
        OpCode = op;
        IdRs   = RW'(rs);
        IdRt   = RW'(rt);
        ExRt   = RW'(exrt);
        ExZero = z;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(T_R, 0, 0, 0, 1'b0);
        RST = 1'b0;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"},  ex_v(),  32'd0);
        chk({tag, "_mem"}, mem_v(), 32'd0);
        chk({tag, "_wb"},  wb_v(),  32'd0);
        chk({tag, "_pcsel"}, 32'(PCSel), 32'd0);
        chk({tag, "_stall"}, 32'(Stall), 32'd0);
        chk({tag, "_flush"}, 32'(FlushIfId), 32'd0);
        chk({tag, "_ill"},   32'(IllegalOp), 32'd0);
        chk({tag, "_cnt"},   32'(StallCount), 32'd0);
    endtask

    initial begin
        // Reset with a jal presented in ID: nothing may leak out.
        drive(T_JAL, 0, 0, 0, 1'b0);
        chk_all_zero("rst");
        RST = 1'b0;
        #1;

        // Plain stream: each bundle appears at Ex/Mem/Wb after 1/2/3 edges.
        for (int k = 0; k < 8; k++) begin
            drive((k < 6) ? t1_op[k] : T_R, 2*k+1, 2*k+2, 20, 1'b0);
            tick();
            if (k < 6) chk("s1_ex", ex_v(), 32'(t1_ex[k]));
            if (k >= 1 && k <= 6) chk("s1_mem", mem_v(), 32'(t1_mem[k-1]));
            if (k >= 2) chk("s1_wb", wb_v(), 32'(t1_wb[k-2]));
        end
        chk("s1_cnt", 32'(StallCount), 32'd0);

        // Load-use on r8, then the same shape with r0.
        do_reset();
        drive(T_LW, 1, 8, 0, 1'b0);
        chk("lu_nostall0", 32'(Stall), 32'd0);
        tick();
        drive(T_R, 8, 9, 8, 1'b0);
        chk("lu_stall", 32'(Stall), 32'd1);
        chk("lu_pcsel", 32'(PCSel), 32'd0);
        chk("lu_flush", 32'(FlushIfId), 32'd0);
        tick();
        chk("lu_bubble", ex_v(), 32'd0);
        chk("lu_mem", mem_v(), 32'b10);
        chk("lu_cnt1", 32'(StallCount), 32'd1);
        drive(T_R, 8, 9, 0, 1'b0);
        chk("lu_stall_once", 32'(Stall), 32'd0);
        tick();
        chk("lu_add", ex_v(), 32'b010010);
        drive(T_LW, 1, 0, 0, 1'b0);
        tick();
        drive(T_R, 0, 9, 0, 1'b0);
        chk("lu_r0", 32'(Stall), 32'd0);
        tick();
        chk("lu_r0_ex", ex_v(), 32'b010010);
        chk("lu_cnt_r0", 32'(StallCount), 32'd1);

        // beq/bne taken and not taken.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(t3_op[c], 1, 2, 0, 1'b0);
            tick();
            chk("br_ex", ex_v(), 32'b000001);
            drive(T_R, 3, 4, 2, t3_z[c]);
            chk("br_pcsel", 32'(PCSel), t3_tk[c] ? 32'd1 : 32'd0);
            chk("br_flush", 32'(FlushIfId), 32'(t3_tk[c]));
            chk("br_stall", 32'(Stall), 32'd0);
            tick();
            chk("br_next", ex_v(), t3_tk[c] ? 32'd0 : 32'b010010);
        end

        // jal writes r31 with PC+4 three edges later.
        do_reset();
        drive(T_JAL, 0, 0, 0, 1'b0);
        chk("jal_pcsel", 32'(PCSel), 32'd2);
        chk("jal_flush", 32'(FlushIfId), 32'd1);
        tick();
        chk("jal_ex", ex_v(), 32'b100000);
        drive(T_R, 1, 2, 0, 1'b0);
        chk("jal_pcsel_after", 32'(PCSel), 32'd0);
        tick();
        chk("jal_mem", mem_v(), 32'd0);
        tick();
        chk("jal_wb", wb_v(), 32'b110);

        // Illegal opcode: suppressed under a taken-branch flush, sticky otherwise.
        do_reset();
        drive(T_BEQ, 1, 2, 0, 1'b0);
        tick();
        drive(T_ILL, 0, 0, 0, 1'b1);
        chk("ill_flush", 32'(FlushIfId), 32'd1);
        tick();
        chk("ill_suppr", 32'(IllegalOp), 32'd0);
        drive(T_ILL, 0, 0, 0, 1'b0);
        chk("ill_pre", 32'(IllegalOp), 32'd0);
        tick();
        chk("ill_set", 32'(IllegalOp), 32'd1);
        chk("ill_ex", ex_v(), 32'd0);
        drive(T_R, 1, 2, 0, 1'b0);
        tick();
        tick();
        chk("ill_sticky", 32'(IllegalOp), 32'd1);
        do_reset();
        chk("ill_clr", 32'(IllegalOp), 32'd0);

        // Asynchronous reset mid-stream with live state everywhere.
        drive(T_ILL, 0, 0, 0, 1'b0);
        tick();
        drive(T_LW, 1, 8, 0, 1'b0);
        tick();
        drive(T_R, 8, 9, 8, 1'b0);
        tick();
        drive(T_R, 8, 9, 0, 1'b0);
        tick();
        chk("ar_pre_wb", wb_v(), 32'b101);
        chk("ar_pre_cnt", 32'(StallCount), 32'd1);
        OpCode = T_JAL;
        RST = 1'b1;
        #1;
        chk_all_zero("ar");
        RST = 1'b0;
        drive(T_ADDI, 1, 2, 0, 1'b0);
        tick();
        chk("ar_first", ex_v(), 32'b001000);

        // Saturation of the 4-bit stall counter over 19 stall events.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(T_LW, 1, 8, 0, 1'b0);
            tick();
            drive(T_R, 8, 9, 8, 1'b0);
            tick();
            if (i == 14) chk("sat_15", 32'(StallCount), 32'd15);
        end
        chk("sat_hold", 32'(StallCount), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
